// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: ROM request/response, branch redirect and decode handshake.
interface if_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  // ROM side
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;

  // Redirect from execute
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;

  // Decode side
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [CntW-1:0]   buf_count;

  // Fetch unit drives the ROM request and the decode-facing head entry.
  modport master (
    output rom_ce,
    output rom_addr,
    input  rom_inst,
    input  branch_flag,
    input  branch_target,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_inst,
    output buf_count
  );

  // Environment: ROM, execute and decode.
  modport slave (
    input  rom_ce,
    input  rom_addr,
    output rom_inst,
    output branch_flag,
    output branch_target,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_inst,
    input  buf_count
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, reads the ROM combinationally each FETCH cycle and
// queues {pc, inst} in a small FIFO toward decode. Branches flush the FIFO and redirect.
module if_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INST_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_unit_if.master fetch_io
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              rom_ce_q;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic push;
  logic pop;
  logic id_valid;

  assign id_valid = (count_q != '0);

  // Next-state: FSM, PC sequencing, FIFO pointers and occupancy.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = 1'b0;
    pop      = id_valid & fetch_io.id_ready;

    unique case (state_q)
      StIdle: begin
        // Branches are ignored until fetching has started.
        state_d = StFetch;
      end
      StFetch: begin
        if (fetch_io.branch_flag) begin
          // Flush discards any coincident pop; decode squashes its own accept.
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          pc_d     = fetch_io.branch_target & ~ADDR_W'(3);
        end else begin
          // A pop frees a slot in the same cycle, so a full FIFO still streams.
          push = (count_q < CntW'(DEPTH)) || pop;
          if (push) begin
            pc_d     = pc_q + ADDR_W'(4);
            wr_ptr_d = wr_ptr_q + PtrW'(1);
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
          end
          if (push && !pop) begin
            count_d = count_q + CntW'(1);
          end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, PC, pointers and registered ROM enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rom_ce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rom_ce_q <= (state_d == StFetch);
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= fetch_io.rom_inst;
    end
  end

  assign fetch_io.rom_ce    = rom_ce_q;
  assign fetch_io.rom_addr  = pc_q;
  assign fetch_io.id_valid  = id_valid;
  assign fetch_io.id_pc     = id_valid ? pc_mem[rd_ptr_q] : '0;
  assign fetch_io.id_inst   = id_valid ? inst_mem[rd_ptr_q] : '0;
  assign fetch_io.buf_count = count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: ROM word[n] = n, checks sequencing, stall, branch, reset.
module tb_if_fetch_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  if_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) bus ();

  if_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .RESET_PC(32'h0000_0000),
    .DEPTH   (DEPTH)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .fetch_io(bus.master)
  );

  // Combinational ROM: word index = byte address / 4, contents = index.
  assign bus.rom_inst = {2'b00, bus.rom_addr[ADDR_W-1:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    rst               = 1'b0;
    bus.id_ready      = 1'b0;
    bus.branch_flag   = 1'b0;
    bus.branch_target = '0;

    // Reset state before any edge.
    #2;
    chk("rst_rom_ce", 64'(bus.rom_ce), 64'd0);
    chk("rst_count", 64'(bus.buf_count), 64'd0);
    chk("rst_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_id_pc", 64'(bus.id_pc), 64'd0);
    chk("rst_id_inst", 64'(bus.id_inst), 64'd0);
    chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);

    // Scenario 1: streaming with id_ready=1.
    bus.id_ready = 1'b1;
    rst          = 1'b1;
    step();
    chk("s1_rom_ce_edge1", 64'(bus.rom_ce), 64'd1);
    chk("s1_valid_edge1", 64'(bus.id_valid), 64'd0);
    chk("s1_addr_edge1", 64'(bus.rom_addr), 64'd0);
    for (int n = 0; n < 4; n++) begin
      step();
      chk("s1_valid", 64'(bus.id_valid), 64'd1);
      chk("s1_id_pc", 64'(bus.id_pc), 64'(4 * n));
      chk("s1_id_inst", 64'(bus.id_inst), 64'(n));
      chk("s1_count", 64'(bus.buf_count), 64'd1);
    end

    // Scenario 2/3: stall with id_ready=0, then full-FIFO pass-through.
    rst          = 1'b0;
    bus.id_ready = 1'b0;
    #2;
    rst = 1'b1;
    step();  // IDLE -> FETCH
    step();  // first push
    chk("s2_count_first", 64'(bus.buf_count), 64'd1);
    chk("s2_pc_first", 64'(bus.id_pc), 64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("s2_count_hold", 64'(bus.buf_count), 64'd2);
      chk("s2_addr_hold", 64'(bus.rom_addr), 64'h8);
      chk("s2_pc_hold", 64'(bus.id_pc), 64'd0);
    end
    bus.id_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("s3_id_pc", 64'(bus.id_pc), 64'(4 * k));
      chk("s3_id_inst", 64'(bus.id_inst), 64'(k));
      chk("s3_count", 64'(bus.buf_count), 64'd2);
      chk("s3_addr", 64'(bus.rom_addr), 64'(8 + 4 * k));
    end

    // Scenario 4: misaligned branch while full; coincident pop discarded.
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'h0000_0103;
    step();
    bus.branch_flag = 1'b0;
    chk("s4_count_flush", 64'(bus.buf_count), 64'd0);
    chk("s4_valid_flush", 64'(bus.id_valid), 64'd0);
    chk("s4_addr_flush", 64'(bus.rom_addr), 64'h100);
    chk("s4_pc_flush", 64'(bus.id_pc), 64'd0);
    step();
    chk("s4_valid_tgt", 64'(bus.id_valid), 64'd1);
    chk("s4_pc_tgt", 64'(bus.id_pc), 64'h100);
    chk("s4_inst_tgt", 64'(bus.id_inst), 64'd64);
    chk("s4_count_tgt", 64'(bus.buf_count), 64'd1);
    step();
    chk("s4_pc_next", 64'(bus.id_pc), 64'h104);
    chk("s4_inst_next", 64'(bus.id_inst), 64'd65);

    // Scenario 5: branch to top of address space, PC wraps to zero.
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    step();
    bus.branch_flag = 1'b0;
    chk("s5_count_flush", 64'(bus.buf_count), 64'd0);
    chk("s5_addr_flush", 64'(bus.rom_addr), 64'hFFFF_FFFC);
    step();
    chk("s5_pc_top", 64'(bus.id_pc), 64'hFFFF_FFFC);
    chk("s5_inst_top", 64'(bus.id_inst), 64'h3FFF_FFFF);
    chk("s5_addr_wrap", 64'(bus.rom_addr), 64'd0);
    step();
    chk("s5_pc_wrap", 64'(bus.id_pc), 64'd0);
    chk("s5_inst_wrap", 64'(bus.id_inst), 64'd0);
    chk("s5_count_wrap", 64'(bus.buf_count), 64'd1);
    step();
    chk("s5_pc_after", 64'(bus.id_pc), 64'd4);

    // Scenario 6: async reset between edges, restart with an ignored IDLE branch.
    #3;
    rst = 1'b0;
    #1;
    chk("s6_valid_async", 64'(bus.id_valid), 64'd0);
    chk("s6_rom_ce_async", 64'(bus.rom_ce), 64'd0);
    chk("s6_count_async", 64'(bus.buf_count), 64'd0);
    chk("s6_addr_async", 64'(bus.rom_addr), 64'd0);
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'h0000_0200;
    #1;
    rst = 1'b1;
    step();
    bus.branch_flag = 1'b0;
    chk("s6_rom_ce_edge1", 64'(bus.rom_ce), 64'd1);
    chk("s6_addr_idle_br", 64'(bus.rom_addr), 64'd0);
    chk("s6_valid_edge1", 64'(bus.id_valid), 64'd0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("s6_id_pc", 64'(bus.id_pc), 64'(4 * n));
      chk("s6_id_inst", 64'(bus.id_inst), 64'(n));
      chk("s6_valid", 64'(bus.id_valid), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
